fetch_unit: RTL

Instruction fetch stage of the single-cycle CPU, sitting directly downstream of the next-PC 3:1 select mux (sequential PC+4 / branch target / jump target). It holds the program counter, issues a request/ready fetch to instruction memory, and presents one captured instruction to decode until the core accepts it. Memory wait states and misaligned next-PC values are handled here, so the rest of the core stays combinational.

---
 rtl/fetch_pkg.sv | 6 +
 rtl/fetch_pc_reg.sv | 25 ++
 rtl/fetch_unit.sv | 79 +++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage
package fetch_pkg;
    typedef enum logic [1:0] {FETCH, HOLD, FAULT} fetch_state_e;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: program counter register with load enable and pc+4 adder
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] plus4_o
);
    logic [WIDTH-1:0] pc_q;

    // PC only moves when the core accepts an advance
    always_ff @(posedge clk) begin
        if (reset) pc_q <= RESET_PC;
        else if (load_i) pc_q <= d_i;
    end

    assign q_o     = pc_q;
    assign plus4_o = pc_q + WIDTH'(4);
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC holder and request/ready instruction fetch; optional FETCH_INSTRET_EN adds a retired-instruction counter
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] next_pc,
    input  logic             advance,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ready,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] instr,
    output logic             instr_valid,
    output logic             misaligned,
    output logic [WIDTH-1:0] instret
);
    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic             misaligned_q, misaligned_d;
    logic             fetch_done, adv_ok, bad_target;

    fetch_pc_reg #(.WIDTH(WIDTH), .RESET_PC(RESET_PC)) u_pc (
        .clk     (clk),
        .reset   (reset),
        .load_i  (adv_ok),
        .d_i     (next_pc),
        .q_o     (pc),
        .plus4_o (pc_plus4)
    );

    // Next state: FETCH waits for memory, HOLD waits for the core, FAULT is terminal
    always_comb begin
        fetch_done   = (state_q == FETCH) && imem_ready;
        adv_ok       = (state_q == HOLD) && advance;
        bad_target   = |next_pc[1:0];
        state_d      = fetch_done ? HOLD : adv_ok ? (bad_target ? FAULT : FETCH) : state_q;
        instr_d      = fetch_done ? imem_rdata : instr_q;
        misaligned_d = misaligned_q | (adv_ok & bad_target);
    end

    // State, captured instruction and sticky fault flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FETCH;
            instr_q      <= NOP_INSTR;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc;
    assign instr       = instr_q;
    assign instr_valid = (state_q == HOLD);
    assign misaligned  = misaligned_q;

`ifdef FETCH_INSTRET_EN
    logic [WIDTH-1:0] instret_q;

    // Count every accepted advance, including the one that faults
    always_ff @(posedge clk) begin
        if (reset) instret_q <= '0;
        else if (adv_ok) instret_q <= instret_q + WIDTH'(1);
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif
endmodule
